tmr_vote_ctrl: RTL and testbench
================================

# tmr_vote_ctrl

Registered triple-modular-redundancy vote controller. It sits behind three redundant copies of a datapath and produces one registered result per valid sample from a bitwise 2-of-3 majority. Per channel it counts consecutive disagreements and retires a channel once it reaches a limit. The vote then degrades from TMR to DMR to FAIL, and a clear input restores full TMR.

## Interface
- `W`, 1 — width of each channel word.
- `FAULT_LIMIT`, 4 — consecutive disagreeing samples that retire a channel; range 1..(2^CNT_W − 1).
- `CNT_W`, 3 — width of each per-channel disagreement counter.

- `clk`  in  1 — single clock; all state updates on the rising edge.
- `rst`  in  1 — synchronous reset, active-high.
- `in_valid`  in  1 — `a`, `b` and `c` carry a sample this cycle.
- `a`, `b`, `c`  in  W — redundant channel words (channels 0, 1, 2).
- `clear_fault`  in  1 — clears all fault state; synchronous, single-cycle.
- `out_valid`  out  1 — `y` is updated this cycle.
- `y`  out  W — voted word.
- `mismatch`  out  3 — per-channel disagreement for the sample now on `y`.
- `faulty`  out  3 — sticky retired-channel flags.
- `mode`  out  2 — 00 TMR, 01 DMR, 10 FAIL.
- `err`  out  1 — the sample on `y` could not be resolved.

## Operation
- **Reset values:** `y`=0, `out_valid`=0, `mismatch`=0, `faulty`=0, `mode`=TMR, `err`=0, all counters 0.
- **TMR** (no channel faulty):
  - `y` = bitwise majority (a&b)|(a&c)|(b&c).
  - Channel i disagrees if its word differs from the voted word in any bit.
- **DMR** (exactly one channel faulty):
  - If the two healthy words are equal, `y` = that word.
  - If they differ, `y` holds its previous value, `err`=1, and no counter changes (the faulty side cannot be identified).
- **FAIL** (two or more channels faulty): `y` holds, `err`=1, `out_valid` still pulses.
- **Per-channel counter** (healthy channels only, valid samples only):
  - A disagreeing sample increments the counter.
  - An agreeing sample resets it to 0.
  - No `in_valid` means hold.
- **Retirement:** when the incremented value equals `FAULT_LIMIT`, `faulty[i]` is set on the same edge and the counter saturates there. A faulty channel is excluded from the vote and its counter is frozen.
- **Mode** is a state machine driven by popcount(`faulty`) and is only ever entered forward (TMR → DMR → FAIL, or TMR → FAIL directly when W>1 lets two channels both disagree and reach the limit on the same edge). Only `rst` or `clear_fault` returns it to TMR.
- **`mismatch[i]`** is registered alongside `y`. It is 0 for faulty channels and 0 in DMR-disagree and FAIL.
- **`clear_fault` together with `in_valid`:** the sample is voted using the pre-clear `faulty` set and emitted normally. Clear wins for state: `faulty`=0, counters=0 and `mode`=TMR after that edge.
- **`rst` during operation:** every output and counter returns to its reset value on the next edge, and any in-flight sample is dropped.

## Timing
- Latency 1 cycle: `out_valid`(t+1) = `in_valid`(t). `y`, `mismatch` and `err` all refer to the sample captured at t.
- Throughput 1 sample per cycle. There is no backpressure.
- When `out_valid`=0, `y` and `mismatch` hold their last values and `err`=0 (`err` is qualified by `out_valid`).
- `faulty` and `mode` change on the same edge that emits the retiring sample. That sample is still voted with the old mode.

## Structure
- Shared package `tmr_pkg`: mode encodings `MODE_TMR`=2'b00, `MODE_DMR`=2'b01, `MODE_FAIL`=2'b10, and channel indices `CH_A`=0, `CH_B`=1, `CH_C`=2.
- Sub-module `tmr_fault_cnt`, instantiated three times. Inputs: `en`, `disagree`, `clear`. Outputs: `faulty` and a saturating CNT_W-bit count.
- Top level holds the combinational majority/DMR select, the mode logic and the output registers.

## Test plan
- **Clean TMR (W=1, cycles 2–8):** a=b=c toggling with `in_valid`=1 → `y` follows one cycle later, `mismatch`=000, `mode`=00, `err`=0.
- **Single fault (FAULT_LIMIT=4):** c=~a, a=b for 4 consecutive valid samples → `y`=a on all four. `mismatch`=3'b100 on each, and on the 4th result `faulty`=3'b100 and `mode`=01.
- **Counter reset:** c disagrees 3 times, agrees once, then disagrees 3 more times → `faulty` stays 000 throughout.
- **DMR disagreement:** `faulty`=3'b100, then a=1, b=0 → `y` holds its prior value, `err`=1, `mismatch`=000, counters unchanged. Follow with a=b=1 → `y`=1, `err`=0.
- **FAIL and clear:** retire b after c → `mode`=10 and `err`=1 on every valid sample. Pulse `clear_fault` together with `in_valid` → that sample has `err`=1 (old mode), then `mode`=00 and `faulty`=000 on the next edge, and subsequent clean samples vote correctly.
- **Reset mid-run:** assert `rst` for one cycle with counters at 2 and `in_valid`=1 → next cycle all outputs are 0 and `mode`=TMR, and a later single disagreement leaves `faulty`=000.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared constants for the TMR vote controller: mode encodings, channel
// indices and a small popcount helper used by the mode state machine.
package tmr_pkg;

  localparam logic [1:0] MODE_TMR  = 2'b00;
  localparam logic [1:0] MODE_DMR  = 2'b01;
  localparam logic [1:0] MODE_FAIL = 2'b10;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_fault_cnt.sv
// Per-channel consecutive-disagreement counter. Counts disagreeing samples
// while enabled, resets on an agreeing sample, and latches a sticky faulty
// flag once the count reaches FAULT_LIMIT. Once faulty the count is frozen
// at the limit until clear or reset.
module tmr_fault_cnt #(
  parameter int CNT_W       = 3,
  parameter int FAULT_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             disagree,
  input  logic             clear,
  output logic             faulty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_LIMIT);

  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);

  // Counter and sticky flag; clear has priority over any sample this cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      faulty <= 1'b0;
    end else if (en && !faulty) begin
      if (disagree) begin
        count <= count_inc;
        if (count_inc == LIMIT) begin
          faulty <= 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/tmr_vote_ctrl.sv
// Registered triple-modular-redundancy vote controller. Votes a bitwise
// 2-of-3 majority in TMR, falls back to the healthy pair in DMR, and
// reports an unresolved result in FAIL. Channels retire after FAULT_LIMIT
// consecutive disagreements; clear_fault restores full TMR.
//
// Handshake: in_valid marks a sample on a/b/c every cycle it is high; there
// is no backpressure. out_valid is in_valid delayed by exactly one cycle and
// qualifies y/mismatch/err (err is forced low when out_valid is low).
module tmr_vote_ctrl
  import tmr_pkg::*;
#(
  parameter int W           = 1,
  parameter int FAULT_LIMIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         clear_fault,
  output logic         out_valid,
  output logic [W-1:0] y,
  output logic [2:0]   mismatch,
  output logic [2:0]   faulty,
  output logic [1:0]   mode,
  output logic         err
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(FAULT_LIMIT - 1);

  logic [W-1:0]     maj;
  logic [W-1:0]     h0;
  logic [W-1:0]     h1;
  logic [W-1:0]     vote_y;
  logic [2:0]       vote_mism;
  logic             vote_err;
  logic             cnt_en;
  logic [CNT_W-1:0] count [3];
  logic [2:0]       retire;
  logic [2:0]       faulty_next;
  logic [1:0]       mode_next;

  assign maj = (a & b) | (a & c) | (b & c);

  // Healthy-pair select for DMR, based on which single channel is retired.
  always_comb begin
    h0 = a;
    h1 = b;
    case (faulty)
      3'b001:  begin h0 = b; h1 = c; end
      3'b010:  begin h0 = a; h1 = c; end
      default: begin h0 = a; h1 = b; end
    endcase
  end

  // Vote result for the current sample, using the mode in force before this edge.
  always_comb begin
    vote_y    = y;
    vote_mism = 3'b000;
    vote_err  = 1'b0;
    cnt_en    = 1'b0;
    case (mode)
      MODE_TMR: begin
        vote_y          = maj;
        vote_mism[CH_A] = (a != maj);
        vote_mism[CH_B] = (b != maj);
        vote_mism[CH_C] = (c != maj);
        cnt_en          = in_valid;
      end
      MODE_DMR: begin
        // A split pair cannot say which side is wrong, so nothing is counted.
        if (h0 == h1) begin
          vote_y = h0;
          cnt_en = in_valid;
        end else begin
          vote_err = 1'b1;
        end
      end
      default: begin
        vote_err = 1'b1;
      end
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    tmr_fault_cnt #(
      .CNT_W       (CNT_W),
      .FAULT_LIMIT (FAULT_LIMIT)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (cnt_en),
      .disagree (vote_mism[i]),
      .clear    (clear_fault),
      .faulty   (faulty[i]),
      .count    (count[i])
    );

    // Channel reaches the limit on this edge; lets mode move on the same edge.
    assign retire[i] = cnt_en && !faulty[i] && vote_mism[i] && (count[i] == LIMIT_M1);
  end

  assign faulty_next = faulty | retire;

  // Forward-only mode transitions from the post-edge retired-channel count.
  always_comb begin
    mode_next = mode;
    case (mode)
      MODE_TMR: begin
        if (popcount3(faulty_next) >= 2'd2) begin
          mode_next = MODE_FAIL;
        end else if (popcount3(faulty_next) == 2'd1) begin
          mode_next = MODE_DMR;
        end
      end
      MODE_DMR: begin
        if (popcount3(faulty_next) >= 2'd2) begin
          mode_next = MODE_FAIL;
        end
      end
      MODE_FAIL: begin
        mode_next = MODE_FAIL;
      end
      default: begin
        mode_next = MODE_TMR;
      end
    endcase
    if (clear_fault) begin
      mode_next = MODE_TMR;
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= MODE_TMR;
    end else begin
      mode <= mode_next;
    end
  end

  // Output registers: capture a voted sample, otherwise hold y/mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      mismatch  <= 3'b000;
      err       <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      y         <= vote_y;
      mismatch  <= vote_mism;
      err       <= vote_err;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed bench for tmr_vote_ctrl with W=2, FAULT_LIMIT=4, CNT_W=3.
module tb_tmr_vote_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] c;
  logic       clear_fault;
  logic       out_valid;
  logic [1:0] y;
  logic [2:0] mismatch;
  logic [2:0] faulty;
  logic [1:0] mode;
  logic       err;

  int checks;
  int failures;

  tmr_vote_ctrl #(
    .W           (2),
    .FAULT_LIMIT (4),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .c           (c),
    .clear_fault (clear_fault),
    .out_valid   (out_valid),
    .y           (y),
    .mismatch    (mismatch),
    .faulty      (faulty),
    .mode        (mode),
    .err         (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs at negedge, sample 1 time unit after posedge.
  task automatic step(input logic v, input logic [1:0] va, input logic [1:0] vb,
                      input logic [1:0] vc, input logic clr, input logic r);
    @(negedge clk);
    in_valid    = v;
    a           = va;
    b           = vb;
    c           = vc;
    clear_fault = clr;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic ov, input logic [1:0] ey,
                            input logic [2:0] em, input logic [2:0] ef,
                            input logic [1:0] emd, input logic ee);
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    check({tag, ".y"},         {6'd0, y},         {6'd0, ey});
    check({tag, ".mismatch"},  {5'd0, mismatch},  {5'd0, em});
    check({tag, ".faulty"},    {5'd0, faulty},    {5'd0, ef});
    check({tag, ".mode"},      {6'd0, mode},      {6'd0, emd});
    check({tag, ".err"},       {7'd0, err},       {7'd0, ee});
  endtask

  initial begin
    logic [1:0] clean_vals [5];
    clean_vals = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = 2'd0;
    b           = 2'd0;
    c           = 2'd0;
    clear_fault = 1'b0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    expect_all("reset", 0, 2'd0, 3'b000, 3'b000, 2'b00, 0);

    // Clean TMR: all channels equal
    for (int i = 0; i < 5; i++) begin
      step(1, clean_vals[i], clean_vals[i], clean_vals[i], 0, 0);
      expect_all("tmr_clean", 1, clean_vals[i], 3'b000, 3'b000, 2'b00, 0);
    end

    // Idle cycle: y holds, err qualified low
    step(0, 0, 1, 2, 0, 0);
    expect_all("idle_hold", 0, 2'd3, 3'b000, 3'b000, 2'b00, 0);

    // Counter reset: 3 disagree, 1 agree, 3 disagree, 1 agree
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 2, 0, 0);
      expect_all("cnt_reset_a", 1, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    end
    step(1, 2, 2, 2, 0, 0);
    expect_all("cnt_reset_agree", 1, 2'd2, 3'b000, 3'b000, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 2, 0, 0);
      expect_all("cnt_reset_b", 1, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    end
    step(1, 2, 2, 2, 0, 0);
    expect_all("cnt_reset_agree2", 1, 2'd2, 3'b000, 3'b000, 2'b00, 0);

    // Single fault on c: retires on the 4th consecutive disagreement
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 2, 1, 0, 0);
      expect_all("single_fault", 1, 2'd2, 3'b100,
                 (i == 3) ? 3'b100 : 3'b000, (i == 3) ? 2'b01 : 2'b00, 0);
    end

    // DMR: c excluded, pair agrees / disagrees / agrees
    step(1, 0, 0, 3, 0, 0);
    expect_all("dmr_agree", 1, 2'd0, 3'b000, 3'b100, 2'b01, 0);
    step(1, 1, 2, 3, 0, 0);
    expect_all("dmr_split", 1, 2'd0, 3'b000, 3'b100, 2'b01, 1);
    step(1, 3, 3, 0, 0, 0);
    expect_all("dmr_agree2", 1, 2'd3, 3'b000, 3'b100, 2'b01, 0);
    step(0, 0, 0, 0, 0, 0);
    expect_all("dmr_idle", 0, 2'd3, 3'b000, 3'b100, 2'b01, 0);

    // Clear without a sample
    step(0, 0, 0, 0, 1, 0);
    expect_all("clear_idle", 0, 2'd3, 3'b000, 3'b000, 2'b00, 0);

    // Counter holds across an idle cycle: 3 + idle + 1 retires c
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 2, 0, 0);
      expect_all("hold_pre", 1, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    end
    step(0, 1, 1, 2, 0, 0);
    expect_all("hold_idle", 0, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    step(1, 1, 1, 2, 0, 0);
    expect_all("hold_retire", 1, 2'd1, 3'b100, 3'b100, 2'b01, 0);

    // Clear together with a clean sample in DMR
    step(1, 1, 1, 1, 1, 0);
    expect_all("clear_dmr", 1, 2'd1, 3'b000, 3'b000, 2'b00, 0);

    // b and c disagree in different bits: both retire on one edge, TMR -> FAIL
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 2, 0, 0);
      expect_all("to_fail", 1, 2'd0, 3'b110,
                 (i == 3) ? 3'b110 : 3'b000, (i == 3) ? 2'b10 : 2'b00, 0);
    end
    step(1, 3, 3, 3, 0, 0);
    expect_all("fail_a", 1, 2'd0, 3'b000, 3'b110, 2'b10, 1);
    step(1, 2, 2, 2, 0, 0);
    expect_all("fail_b", 1, 2'd0, 3'b000, 3'b110, 2'b10, 1);

    // Clear with a sample in FAIL: sample uses old mode, state clears
    step(1, 3, 3, 3, 1, 0);
    expect_all("clear_fail", 1, 2'd0, 3'b000, 3'b000, 2'b00, 1);
    step(1, 2, 2, 2, 0, 0);
    expect_all("post_clear", 1, 2'd2, 3'b000, 3'b000, 2'b00, 0);

    // Reset mid-run with c's counter at 2 and a sample in flight
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 0, 0, 0);
      expect_all("pre_rst", 1, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    end
    step(1, 1, 1, 0, 0, 1);
    expect_all("mid_rst", 0, 2'd0, 3'b000, 3'b000, 2'b00, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 0, 0, 0);
      expect_all("post_rst", 1, 2'd1, 3'b100, 3'b000, 2'b00, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
